axil_write_regfile: RTL

AXI4-Lite write-side slave that terminates the write address (AW), write data (W) and write response (B) channels. It sits directly downstream of the write-data channel stage, consuming the WDATA/WSTRB beats it delivers. It joins each AW beat with one W beat, commits the byte-strobed data into a bank of 32-bit registers, and returns a B response. A combinational read-out port exposes the register bank to local logic.

---
 rtl/axil_pkg.sv | 34 +++
 rtl/axil_strb_reg.sv | 28 ++
 rtl/axil_write_regfile.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite write-side register file.
package axil_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Replace the byte lanes selected by strb with the matching lanes of new_val.
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_strb_reg.sv
// One 32-bit register with per-byte write enables.
module axil_strb_reg
  import axil_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [STRB_W-1:0] strb,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_r;

  // Storage with synchronous clear and byte-strobed update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= {DATA_W{1'b0}};
    end else if (en) begin
      q_r <= strb_merge(q_r, din, strb);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/axil_write_regfile.sv
// AXI4-Lite write slave joining AW and W beats into a bank of byte-strobed registers.
// Optional macro AXIL_WR_SLVERR_EN: reject out-of-range addresses with SLVERR.
module axil_write_regfile
  import axil_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       AWADDR,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic [IDX_W-1:0]  RD_IDX,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              WR_PULSE
);

  state_t              state_r, state_nxt_s;
  logic                aw_full_r, aw_full_nxt_s;
  logic                w_full_r, w_full_nxt_s;
  logic [IDX_W-1:0]    idx_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic                awready_r, wready_r, bvalid_r, wr_pulse_r;
  logic [1:0]          bresp_r;
  logic                aw_hs_s, w_hs_s, commit_ok_s;
  logic [DATA_W-1:0]   regs_s [NUM_REGS];

  assign aw_hs_s = AWVALID && awready_r;
  assign w_hs_s  = WVALID && wready_r;

`ifdef AXIL_WR_SLVERR_EN
  logic oor_r, oor_nxt_s;
  logic unused_s;
  assign unused_s = ^AWADDR[1:0];

  // Out-of-range flag follows the address captured into the AW holding register.
  always_comb begin
    oor_nxt_s = oor_r;
    if (aw_hs_s) begin
      oor_nxt_s = (AWADDR[31:IDX_W+2] != {(30-IDX_W){1'b0}});
    end else begin
      oor_nxt_s = oor_r;
    end
  end

  // Out-of-range flag register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      oor_r <= 1'b0;
    end else begin
      oor_r <= oor_nxt_s;
    end
  end

  assign commit_ok_s = !oor_nxt_s;
`else
  logic unused_s;
  assign unused_s    = ^{AWADDR[31:IDX_W+2], AWADDR[1:0]};
  assign commit_ok_s = 1'b1;
`endif

  // Next-state and holding-register occupancy.
  always_comb begin
    state_nxt_s   = state_r;
    aw_full_nxt_s = aw_full_r;
    w_full_nxt_s  = w_full_r;
    case (state_r)
      IDLE: begin
        aw_full_nxt_s = aw_full_r | aw_hs_s;
        w_full_nxt_s  = w_full_r | w_hs_s;
        if (aw_full_nxt_s && w_full_nxt_s) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COMMIT: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (BREADY) begin
          state_nxt_s   = IDLE;
          aw_full_nxt_s = 1'b0;
          w_full_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        aw_full_nxt_s = 1'b0;
        w_full_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, holding registers and registered handshake outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r    <= IDLE;
      aw_full_r  <= 1'b0;
      w_full_r   <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      wstrb_r    <= {STRB_W{1'b0}};
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      aw_full_r <= aw_full_nxt_s;
      w_full_r  <= w_full_nxt_s;
      if (aw_hs_s) begin
        idx_r <= AWADDR[IDX_W+1:2];
      end
      if (w_hs_s) begin
        wdata_r <= WDATA;
        wstrb_r <= WSTRB;
      end
      // READYs are computed one edge early so they are clean flops.
      awready_r  <= (state_nxt_s == IDLE) && !aw_full_nxt_s;
      wready_r   <= (state_nxt_s == IDLE) && !w_full_nxt_s;
      bvalid_r   <= (state_nxt_s == RESP);
      wr_pulse_r <= (state_r == IDLE) && (state_nxt_s == COMMIT) && commit_ok_s;
      if (state_r == COMMIT) begin
        bresp_r <= commit_ok_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // WR_PULSE is high exactly during a committing COMMIT cycle, so it doubles as the write enable.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    axil_strb_reg u_reg (
      .clk  (ACLK),
      .rst  (ARESET),
      .en   (wr_pulse_r && (idx_r == IDX_W'(g))),
      .strb (wstrb_r),
      .din  (wdata_r),
      .q    (regs_s[g])
    );
  end

  assign AWREADY  = awready_r;
  assign WREADY   = wready_r;
  assign BVALID   = bvalid_r;
  assign BRESP    = bresp_r;
  assign WR_PULSE = wr_pulse_r;
  assign RD_DATA  = regs_s[RD_IDX];

endmodule
